multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clk  in  1  single clock; all state updates on its rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 inInstructionOpcode  in  6  opcode field instr[31:26] from the instruction register, valid from DECODE onward.
REQ-004 inMemReady  in  1  memory handshake; high means the current read or write completes this cycle.
REQ-005 outPCWrite, outPCWriteCond, outIorD, outMemRead, outMemWrite, outMemtoReg, outIRWrite, outRegWrite, outRegDst, outALUSrcA  out  1 each  datapath strobes and mux selects.
REQ-006 outALUSrcB, outPCSource, outALUop  out  2 each  mux selects; outALUop feeds the existing ALU control decoder (00 add, 01 subtract, 10 funct-decoded).
REQ-007 outIllegal  out  1  one-cycle pulse when an unsupported opcode is decoded.
REQ-008 outState  out  4  current state encoding, for debug.
REQ-009 outInstrCount  out  16  count of completed instruction fetches.

Function
REQ-010 Decoded opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000; all others are illegal.
REQ-011 States and encodings: FETCH 0, DECODE 1, MEMADDR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, RCOMPLETE 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11; codes 12-15 return to FETCH on the next edge.
REQ-012 Transitions:
- FETCH -> DECODE when inMemReady=1; otherwise hold in FETCH.
- DECODE -> MEMADDR for lw/sw, EXECUTE for R-type, BRANCH for beq, JUMP for j, ADDIEX for addi; illegal opcode -> FETCH.
- MEMADDR -> MEMREAD for lw, MEMWRITE for sw.
- MEMREAD -> MEMWB when inMemReady=1; otherwise hold.
- MEMWRITE -> FETCH when inMemReady=1; otherwise hold.
- EXECUTE -> RCOMPLETE; ADDIEX -> ADDIWB.
- MEMWB, RCOMPLETE, BRANCH, JUMP, ADDIWB -> FETCH.
REQ-013 Per-state outputs (unlisted signals are 0):
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00; IRWrite=PCWrite=inMemReady.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=00.
- MEMADDR and ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUop=00.
- MEMREAD: MemRead=1, IorD=1.
- MEMWRITE: MemWrite=1, IorD=1.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUop=10.
- RCOMPLETE: RegWrite=1, RegDst=1, MemtoReg=0.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01.
- JUMP: PCWrite=1, PCSource=10.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0.
REQ-014 outIllegal shall be 1 exactly during the DECODE cycle whose opcode is illegal.
REQ-015 outInstrCount shall increment on each edge where the state is FETCH and inMemReady=1, and shall wrap from 0xFFFF to 0x0000.
REQ-016 Latency in cycles with no wait states: j 3; beq 3; R-type 4; addi 4; sw 4; lw 5; each inMemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
REQ-017 outRegWrite and outMemWrite shall never both be 1 in the same cycle.

Reset
REQ-018 While rst=1: state=FETCH; outInstrCount=0; every control output, including MemRead, IRWrite, PCWrite and outIllegal, is forced to 0.
REQ-019 The first edge after rst falls shall begin a normal FETCH, with FETCH outputs driven.
REQ-020 Reset asserted in any state, including during a memory wait, shall abort the instruction immediately, with no RegWrite, MemWrite or PCWrite issued.

Structure
REQ-021 State encodings, opcode constants and ALUop codes shall live in a shared defines file, also used by the ALU control decoder.
REQ-022 The block shall consist of a registered state plus counter, a combinational next-state function, and one sub-module, mc_output_decode, that maps state and inMemReady to the control word.

Verification
REQ-023 lw, inMemReady always 1 -> state sequence 0,1,2,3,4,0; outRegWrite=1 and outMemtoReg=1 only in state 4; outInstrCount +1.
REQ-024 sw with inMemReady=0 for 3 cycles in MEMWRITE -> outMemWrite=1 held for 4 cycles, then FETCH; no outRegWrite.
REQ-025 Opcode 111111 -> outIllegal=1 for one cycle in DECODE, then FETCH; no write strobes.
REQ-026 Sequence R-type, beq, j, addi -> outALUop 10 in EXECUTE, 01 in BRANCH; outPCSource 10 in JUMP; outRegDst 1 in RCOMPLETE and 0 in ADDIWB.
REQ-027 rst asserted mid-MEMREAD wait -> all outputs 0 asynchronously; after release, FETCH with outMemRead=1 and outInstrCount=0.
REQ-028 Preload outInstrCount to 0xFFFF (65535 fetches), then one more fetch -> count reads 0x0000.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
//-----------------------------------------------------------------------------
// multicycle_control_pkg
// Shared definitions for the multicycle controller and the ALU control
// decoder. It holds the state encodings, the decoded opcodes, the ALUop codes
// and the packed control word that the output decoder produces.
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package multicycle_control_pkg;

   // Controller states. The encodings are visible on the debug port.
   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEMADDR   = 4'd2,
      S_MEMREAD   = 4'd3,
      S_MEMWB     = 4'd4,
      S_MEMWRITE  = 4'd5,
      S_EXECUTE   = 4'd6,
      S_RCOMPLETE = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDIEX    = 4'd10,
      S_ADDIWB    = 4'd11
   } state_t;

   // Opcodes taken from instr[31:26]
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   // ALUop codes understood by the ALU control decoder
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // Datapath control word
   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       ir_write;
      logic       reg_write;
      logic       reg_dst;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic [1:0] alu_op;
   } ctrl_t;

   // True for the opcodes this controller knows how to sequence
   function automatic logic is_legal_opcode(input logic [5:0] opcode);
      case (opcode)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: is_legal_opcode = 1'b1;
         default:                                       is_legal_opcode = 1'b0;
      endcase
   endfunction

endpackage : multicycle_control_pkg

`default_nettype wire

// File: rtl/multicycle_control_output_decode.sv
//-----------------------------------------------------------------------------
// mc_output_decode
// Maps the current controller state and the memory handshake to the
// datapath control word. Purely combinational.
//   state     in  current controller state
//   mem_ready in  memory handshake (gates IR and PC writes in FETCH)
//   ctrl      out control word
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module mc_output_decode
   import multicycle_control_pkg::*;
(
   input  state_t state,
   input  logic   mem_ready,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = 2'b01;
            ctrl.alu_op    = ALUOP_ADD;
            // IR and PC only capture once the instruction word has arrived
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b = 2'b11;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEMADDR, S_ADDIEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b10;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEMREAD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
         end
         S_MEMWRITE: begin
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_EXECUTE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b00;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_RCOMPLETE: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = 2'b00;
            ctrl.alu_op        = ALUOP_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = 2'b01;
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = 2'b10;
         end
         S_ADDIWB: begin
            ctrl.reg_write = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule : mc_output_decode

`default_nettype wire

// File: rtl/multicycle_control.sv
//-----------------------------------------------------------------------------
// multicycle_control
// Main controller for a multicycle MIPS-style datapath. Holds the state
// register and the fetch counter, computes the next state from the opcode and
// the memory handshake, and drives the control word through mc_output_decode.
//   clk                 in  clock
//   rst                 in  asynchronous active-high reset
//   inInstructionOpcode in  instr[31:26]
//   inMemReady          in  memory access completes this cycle
//   out*                out datapath strobes and mux selects
//   outIllegal          out unsupported opcode seen in DECODE
//   outState            out current state (debug)
//   outInstrCount       out completed instruction fetches, wraps at 16 bits
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module multicycle_control
   import multicycle_control_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  inInstructionOpcode,
   input  logic        inMemReady,
   output logic        outPCWrite,
   output logic        outPCWriteCond,
   output logic        outIorD,
   output logic        outMemRead,
   output logic        outMemWrite,
   output logic        outMemtoReg,
   output logic        outIRWrite,
   output logic        outRegWrite,
   output logic        outRegDst,
   output logic        outALUSrcA,
   output logic [1:0]  outALUSrcB,
   output logic [1:0]  outPCSource,
   output logic [1:0]  outALUop,
   output logic        outIllegal,
   output logic [3:0]  outState,
   output logic [15:0] outInstrCount
);

   state_t      state;
   state_t      state_next;
   logic [15:0] instr_count;
   ctrl_t       ctrl_dec;
   ctrl_t       ctrl;
   logic        fetch_done;

   assign fetch_done = (state == S_FETCH) && inMemReady;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_FETCH;
      end else begin
         state <= state_next;
      end
   end

   // Completed-fetch counter; natural 16-bit wrap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_count <= 16'd0;
      end else if (fetch_done) begin
         instr_count <= instr_count + 16'd1;
      end
   end

   // Next-state function
   always_comb begin
      state_next = S_FETCH;
      case (state)
         S_FETCH:    state_next = inMemReady ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (inInstructionOpcode)
               OP_LW, OP_SW: state_next = S_MEMADDR;
               OP_RTYPE:     state_next = S_EXECUTE;
               OP_BEQ:       state_next = S_BRANCH;
               OP_J:         state_next = S_JUMP;
               OP_ADDI:      state_next = S_ADDIEX;
               default:      state_next = S_FETCH;
            endcase
         end
         S_MEMADDR: begin
            // Any other opcode here can only come from a disturbed IR;
            // abandon the instruction rather than guess.
            if (inInstructionOpcode == OP_LW) begin
               state_next = S_MEMREAD;
            end else if (inInstructionOpcode == OP_SW) begin
               state_next = S_MEMWRITE;
            end else begin
               state_next = S_FETCH;
            end
         end
         S_MEMREAD:  state_next = inMemReady ? S_MEMWB : S_MEMREAD;
         S_MEMWRITE: state_next = inMemReady ? S_FETCH : S_MEMWRITE;
         S_EXECUTE:  state_next = S_RCOMPLETE;
         S_ADDIEX:   state_next = S_ADDIWB;
         S_MEMWB, S_RCOMPLETE, S_BRANCH, S_JUMP, S_ADDIWB: state_next = S_FETCH;
         // Unused codes 12-15 recover to FETCH
         default:    state_next = S_FETCH;
      endcase
   end

   mc_output_decode u_output_decode (
      .state     (state),
      .mem_ready (inMemReady),
      .ctrl      (ctrl_dec)
   );

   // FETCH drives MemRead from its decode, so reset must also mask the
   // control word combinationally to keep every strobe low while rst is high.
   assign ctrl = rst ? '0 : ctrl_dec;

   assign outPCWrite     = ctrl.pc_write;
   assign outPCWriteCond = ctrl.pc_write_cond;
   assign outIorD        = ctrl.iord;
   assign outMemRead     = ctrl.mem_read;
   assign outMemWrite    = ctrl.mem_write;
   assign outMemtoReg    = ctrl.mem_to_reg;
   assign outIRWrite     = ctrl.ir_write;
   assign outRegWrite    = ctrl.reg_write;
   assign outRegDst      = ctrl.reg_dst;
   assign outALUSrcA     = ctrl.alu_src_a;
   assign outALUSrcB     = ctrl.alu_src_b;
   assign outPCSource    = ctrl.pc_source;
   assign outALUop       = ctrl.alu_op;

   assign outIllegal    = !rst && (state == S_DECODE) && !is_legal_opcode(inInstructionOpcode);
   assign outState      = state;
   assign outInstrCount = instr_count;

endmodule : multicycle_control

`default_nettype wire

// File: tb/tb_multicycle_control.sv
//-----------------------------------------------------------------------------
// tb_multicycle_control
// Scoreboard bench for multicycle_control. Stimulus drives one cycle at a
// time and queues the expected state, control word, illegal flag and count
// for that cycle; a monitor pops and compares on the falling edge.
// Revision: 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_multicycle_control;

   localparam logic [5:0] C_LW   = 6'b100011;
   localparam logic [5:0] C_SW   = 6'b101011;
   localparam logic [5:0] C_R    = 6'b000000;
   localparam logic [5:0] C_BEQ  = 6'b000100;
   localparam logic [5:0] C_J    = 6'b000010;
   localparam logic [5:0] C_ADDI = 6'b001000;
   localparam logic [5:0] C_ILL  = 6'b111111;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  op;
   logic        mr;
   logic        pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rd, asa;
   logic [1:0]  asb, pcs, aop;
   logic        ill;
   logic [3:0]  st;
   logic [15:0] cnt;

   multicycle_control dut (
      .clk                 (clk),
      .rst                 (rst),
      .inInstructionOpcode (op),
      .inMemReady          (mr),
      .outPCWrite          (pcw),
      .outPCWriteCond      (pcwc),
      .outIorD             (iord),
      .outMemRead          (mrd),
      .outMemWrite         (mwr),
      .outMemtoReg         (m2r),
      .outIRWrite          (irw),
      .outRegWrite         (rw),
      .outRegDst           (rd),
      .outALUSrcA          (asa),
      .outALUSrcB          (asb),
      .outPCSource         (pcs),
      .outALUop            (aop),
      .outIllegal          (ill),
      .outState            (st),
      .outInstrCount       (cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  st;
      logic [15:0] w;
      logic        ill;
      logic [15:0] cnt;
   } rec_t;

   rec_t        q[$];
   int          total  = 0;
   int          passed = 0;
   int          nrec   = 0;
   logic [15:0] exp_cnt;

   // Expected control word per state, field order:
   // PCWrite PCWriteCond IorD MemRead MemWrite MemtoReg IRWrite RegWrite
   // RegDst ALUSrcA ALUSrcB[2] PCSource[2] ALUop[2]
   function automatic logic [15:0] word_for(input logic [3:0] s, input logic m);
      logic e_pcw, e_pcwc, e_iord, e_mrd, e_mwr, e_m2r, e_irw, e_rw, e_rd, e_asa;
      logic [1:0] e_asb, e_pcs, e_aop;
      {e_pcw, e_pcwc, e_iord, e_mrd, e_mwr, e_m2r, e_irw, e_rw, e_rd, e_asa} = '0;
      e_asb = 2'b00; e_pcs = 2'b00; e_aop = 2'b00;
      case (s)
         4'd0:  begin e_mrd = 1'b1; e_asb = 2'b01; e_irw = m; e_pcw = m; end
         4'd1:  e_asb = 2'b11;
         4'd2,
         4'd10: begin e_asa = 1'b1; e_asb = 2'b10; end
         4'd3:  begin e_mrd = 1'b1; e_iord = 1'b1; end
         4'd5:  begin e_mwr = 1'b1; e_iord = 1'b1; end
         4'd4:  begin e_rw = 1'b1; e_m2r = 1'b1; end
         4'd6:  begin e_asa = 1'b1; e_aop = 2'b10; end
         4'd7:  begin e_rw = 1'b1; e_rd = 1'b1; end
         4'd8:  begin e_asa = 1'b1; e_aop = 2'b01; e_pcwc = 1'b1; e_pcs = 2'b01; end
         4'd9:  begin e_pcw = 1'b1; e_pcs = 2'b10; end
         4'd11: e_rw = 1'b1;
         default: ;
      endcase
      return {e_pcw, e_pcwc, e_iord, e_mrd, e_mwr, e_m2r, e_irw, e_rw, e_rd, e_asa,
              e_asb, e_pcs, e_aop};
   endfunction

   // Monitor: one record per cycle, compared away from the active edge
   always @(negedge clk) begin
      if (q.size() > 0) begin
         rec_t e;
         rec_t a;
         e = q.pop_front();
         a = {st, {pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rd, asa, asb, pcs, aop}, ill, cnt};
         total++;
         if (a === e) passed++;
         else $display("FAIL rec%0d state=%0d/%0d word=%h/%h illegal=%b/%b count=%h/%h (actual/required)",
                       nrec, a.st, e.st, a.w, e.w, a.ill, e.ill, a.cnt, e.cnt);
         total++;
         if (!(rw && mwr)) passed++;
         else $display("FAIL rec%0d regwrite_memwrite_both actual=11 required=not both", nrec);
         nrec++;
      end
   end

   // Drive one cycle and queue what it must show
   task automatic step(input logic [5:0] o, input logic m, input logic [3:0] s, input logic il);
      op = o;
      mr = m;
      q.push_back({s, word_for(s, m), il, exp_cnt});
      if (s == 4'd0 && m) exp_cnt = exp_cnt + 16'd1;
      @(posedge clk);
      #1;
   endtask

   task automatic reset_cycle();
      rst = 1'b1;
      mr  = 1'b0;
      exp_cnt = 16'd0;
      q.push_back({4'd0, 16'd0, 1'b0, 16'd0});
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      op  = 6'd0;
      mr  = 1'b0;
      exp_cnt = 16'd0;
      @(posedge clk);
      #1;
      reset_cycle();

      // lw, no waits
      step(C_LW, 1, 0, 0); step(C_LW, 1, 1, 0); step(C_LW, 1, 2, 0);
      step(C_LW, 1, 3, 0); step(C_LW, 1, 4, 0);

      // sw with three wait cycles in MEMWRITE
      step(C_SW, 1, 0, 0); step(C_SW, 1, 1, 0); step(C_SW, 1, 2, 0);
      step(C_SW, 0, 5, 0); step(C_SW, 0, 5, 0); step(C_SW, 0, 5, 0);
      step(C_SW, 1, 5, 0);

      // illegal opcode, preceded by a FETCH wait
      step(C_ILL, 0, 0, 0); step(C_ILL, 1, 0, 0); step(C_ILL, 1, 1, 1);

      // R-type, beq, j, addi
      step(C_R, 1, 0, 0);    step(C_R, 1, 1, 0);    step(C_R, 1, 6, 0);    step(C_R, 1, 7, 0);
      step(C_BEQ, 1, 0, 0);  step(C_BEQ, 1, 1, 0);  step(C_BEQ, 1, 8, 0);
      step(C_J, 1, 0, 0);    step(C_J, 1, 1, 0);    step(C_J, 1, 9, 0);
      step(C_ADDI, 1, 0, 0); step(C_ADDI, 1, 1, 0); step(C_ADDI, 1, 10, 0); step(C_ADDI, 1, 11, 0);

      // lw aborted by reset during a MEMREAD wait
      step(C_LW, 1, 0, 0); step(C_LW, 1, 1, 0); step(C_LW, 1, 2, 0);
      step(C_LW, 0, 3, 0); step(C_LW, 0, 3, 0);
      reset_cycle();
      step(C_J, 1, 0, 0); step(C_J, 1, 1, 0); step(C_J, 1, 9, 0);

      // counter wrap: park in FETCH, preload 0xFFFF, then one more fetch
      step(C_J, 0, 0, 0);
      force dut.instr_count = 16'hFFFF;
      #1;
      release dut.instr_count;
      exp_cnt = 16'hFFFF;
      step(C_J, 0, 0, 0); step(C_J, 1, 0, 0); step(C_J, 1, 1, 0);
      step(C_J, 1, 9, 0); step(C_J, 1, 0, 0);

      // bounded drain of the scoreboard
      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      total++;
      if (q.size() == 0) passed++;
      else $display("FAIL drain pending=%0d required=0", q.size());

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_multicycle_control

`default_nettype wire
